// File: rtl/hier_rr_dispatch.sv
// hier_rr_dispatch: round-robin dispatcher feeding NUM_CHILD child slots
// from a single valid/ready stream through a one-entry holding register.
// Keeps a saturating count of completed dispatches.
// Optional feature macro: HIER_DISPATCH_TIMEOUT_EN. When it is defined, a
// word that waits TIMEOUT cycles on a stalled child is moved to the next
// child in the ring and timeout_o pulses for one cycle.
module hier_rr_dispatch #(
  parameter int NUM_CHILD = 10,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic [NUM_CHILD-1:0] out_valid,
  input  logic [NUM_CHILD-1:0] out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [CNT_W-1:0]     sent_cnt,
  output logic                 timeout_o
);

  localparam int IDX_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CHILD - 1);
  localparam logic [NUM_CHILD-1:0] ONE_HOT  = NUM_CHILD'(1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

  // Reject configurations outside the supported range at elaboration time.
  if (NUM_CHILD < 2 || NUM_CHILD > 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("hier_rr_dispatch: NUM_CHILD must be 2..16 and TIMEOUT >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  tgt_q, tgt_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full;
  logic              out_fire;
  logic              in_fire;
  logic              expire;

  // Next child in the ring, wrapping the last slot back to slot 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  assign full      = (state_q == HOLD);
  assign out_fire  = full & out_ready[tgt_q];
  assign in_ready  = ~full | out_fire;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = full ? (ONE_HOT << tgt_q) : '0;
  assign out_data  = data_q;
  assign sent_cnt  = cnt_q;

`ifdef HIER_DISPATCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;

  // A stalled word expires on its last allowed cycle unless it fires then.
  assign expire    = full & ~out_fire & (wait_q == WAIT_LAST);
  assign timeout_o = timeout_q;

  // Wait counter: counts stalled HOLD cycles, clears on load, fire or expiry.
  always_comb begin
    wait_d    = wait_q;
    timeout_d = 1'b0;
    if (!full || out_fire) begin
      wait_d = '0;
    end else if (expire) begin
      wait_d    = '0;
      timeout_d = 1'b1;
    end else begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Wait counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state logic: load, dispatch/reload, or re-target the held word.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          state_d = HOLD;
          data_d  = in_data;
          tgt_d   = rr_ptr_q;
        end
      end
      HOLD: begin
        if (out_fire) begin
          if (in_fire) begin
            data_d   = in_data;
            tgt_d    = wrap_inc(tgt_q);
            rr_ptr_d = wrap_inc(wrap_inc(tgt_q));
          end else begin
            state_d  = IDLE;
            rr_ptr_d = wrap_inc(tgt_q);
          end
        end else if (expire) begin
          tgt_d = wrap_inc(tgt_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Dispatch counter: one step per completed dispatch, stuck at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, target, pointer, payload and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      rr_ptr_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
